// File: rtl/gpio_in_cond_if.sv
// Purpose : pin-level bundle between a GPIO input conditioner and its user.
// Latency : none (plain wires).
// Backpressure: none; levels and strobes are sampled every MCLK.
// Signals : pad_in/db_en are driven by the master (pad side / config),
//           pin_out/edge_rise/edge_fall are driven by the slave (conditioner).
interface gpio_in_cond_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pad_in;     // raw asynchronous pad levels
  logic [WIDTH-1:0] db_en;      // per-pin debounce enable, MCLK domain
  logic [WIDTH-1:0] pin_out;    // conditioned level
  logic [WIDTH-1:0] edge_rise;  // one-cycle 0->1 strobe, coincident with pin_out
  logic [WIDTH-1:0] edge_fall;  // one-cycle 1->0 strobe, coincident with pin_out

  modport master (
    output pad_in,
    output db_en,
    input  pin_out,
    input  edge_rise,
    input  edge_fall
  );

  modport slave (
    input  pad_in,
    input  db_en,
    output pin_out,
    output edge_rise,
    output edge_fall
  );
endinterface

// File: rtl/gpio_in_cond.sv
// Purpose : 2-FF synchronizer plus optional per-pin debounce in front of GPIO16 {PyIN,PxIN}.
// Latency : pad->pin_out 3 edges in bypass, 2+DB_CYCLES edges with debounce enabled.
// Backpressure: none; every pin is re-evaluated on every MCLK edge.
// Ports   : MCLK (clock), reset (async, active-low), bus (slave side of gpio_in_cond_if):
//           pad_in, db_en in; pin_out, edge_rise, edge_fall out (all outputs registered).
module gpio_in_cond #(
  parameter int               WIDTH     = 16,
  parameter int               DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input logic           MCLK,
  input logic           reset,
  gpio_in_cond_if.slave bus
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // Count value at which the next disagreeing sample commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            pin_q,   pin_d;
  logic [WIDTH-1:0]            rise_q,  rise_d;
  logic [WIDTH-1:0]            fall_q,  fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    // Synchronizer stages carry no logic between them.
    sync1_d = bus.pad_in;
    sync2_d = sync1_q;
    pin_d   = pin_q;
    // Every path that does not extend a disagreement streak clears the count.
    cnt_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.db_en[i]) begin
        pin_d[i] = sync2_q[i];
      end else if (sync2_q[i] != pin_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          pin_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    // Strobes are registered alongside pin_out so they land in the same cycle.
    rise_d = ~pin_q &  pin_d;
    fall_d =  pin_q & ~pin_d;
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      pin_q   <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pin_q   <= pin_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pin_out   = pin_q;
  assign bus.edge_rise = rise_q;
  assign bus.edge_fall = fall_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;

  localparam int          W    = 16;
  localparam int          DB   = 4;
  localparam logic [15:0] RSTV = 16'h0000;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  gpio_in_cond_if #(.WIDTH(W)) bus ();

  gpio_in_cond #(
    .WIDTH(W),
    .DB_CYCLES(DB),
    .RST_VAL(RSTV)
  ) dut (
    .MCLK(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The conditioner sees each pad value two edges late. A pin flips once the
  // last DB consecutive samples (all with debounce enabled) disagree with it;
  // with debounce off it simply follows the delayed sample.
  logic [15:0] m_pin, m_rise, m_fall;
  logic [15:0] dly[$];
  logic [15:0] hist_s[$];
  logic [15:0] hist_e[$];
  logic [15:0] smp, nxt;
  int          run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pin  = RSTV;
      m_rise = '0;
      m_fall = '0;
      dly    = '{RSTV, RSTV};
      hist_s.delete();
      hist_e.delete();
    end else begin
      smp = dly.pop_front();
      dly.push_back(bus.pad_in);
      hist_s.push_back(smp);
      hist_e.push_back(bus.db_en);
      if (hist_s.size() > DB) begin
        void'(hist_s.pop_front());
        void'(hist_e.pop_front());
      end
      nxt = m_pin;
      for (int i = 0; i < W; i++) begin
        if (!bus.db_en[i]) begin
          nxt[i] = smp[i];
        end else begin
          run = 0;
          for (int j = hist_s.size() - 1; j >= 0; j--) begin
            if (hist_e[j][i] && (hist_s[j][i] != m_pin[i])) run++;
            else break;
          end
          if (run >= DB) nxt[i] = smp[i];
        end
      end
      m_rise = ~m_pin & nxt;
      m_fall = m_pin & ~nxt;
      m_pin  = nxt;
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_pin_out", bus.pin_out, m_pin);
    chk("cyc_edge_rise", bus.edge_rise, m_rise);
    chk("cyc_edge_fall", bus.edge_fall, m_fall);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [15:0] flip;
  int          fast;

  initial begin
    checks = 0;
    errors = 0;
    rst_n       = 1'b0;
    bus.pad_in  = 16'hFFFF;
    bus.db_en   = 16'hFFFF;

    // 1: reset holds outputs, release gives single rise after 6 edges
    step(3);
    chk("rst_pin", bus.pin_out, 16'h0000);
    chk("rst_rise", bus.edge_rise, 16'h0000);
    chk("rst_fall", bus.edge_fall, 16'h0000);
    rst_n = 1'b1;
    step(5);
    chk("t1_pin_e5", bus.pin_out, 16'h0000);
    step();
    chk("t1_pin_e6", bus.pin_out, 16'hFFFF);
    chk("t1_rise_e6", bus.edge_rise, 16'hFFFF);
    step();
    chk("t1_rise_e7", bus.edge_rise, 16'h0000);

    // 2: bypass latency
    bus.db_en  = 16'h0000;
    bus.pad_in = 16'h0000;
    step(5);
    chk("t2_pin_idle", bus.pin_out, 16'h0000);
    bus.pad_in = 16'hA55A;
    step(2);
    chk("t2_pin_e2", bus.pin_out, 16'h0000);
    step();
    chk("t2_pin_e3", bus.pin_out, 16'hA55A);
    chk("t2_rise_e3", bus.edge_rise, 16'hA55A);
    chk("t2_fall_e3", bus.edge_fall, 16'h0000);
    step();
    chk("t2_rise_e4", bus.edge_rise, 16'h0000);

    // 3: debounced fall on pin 1
    bus.db_en  = 16'hFFFF;
    bus.pad_in = 16'hFFFF;
    step(8);
    bus.pad_in = 16'hFFFD;
    step(5);
    chk("t3_pin_e5", bus.pin_out, 16'hFFFF);
    step();
    chk("t3_pin_e6", bus.pin_out, 16'hFFFD);
    chk("t3_fall_e6", bus.edge_fall, 16'h0002);
    step();
    chk("t3_fall_e7", bus.edge_fall, 16'h0000);

    // 4: 3-cycle glitch rejected, 4-cycle glitch accepted both ways
    bus.pad_in = 16'hFFFF;
    step(8);
    bus.pad_in = 16'hFFFB;
    step(3);
    bus.pad_in = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_glitch_pin", bus.pin_out & 16'h0004, 16'h0004);
      chk("t4_glitch_strobe", (bus.edge_rise | bus.edge_fall) & 16'h0004, 16'h0000);
    end
    bus.pad_in = 16'hFFFB;
    step(4);
    bus.pad_in = 16'hFFFF;
    step(2);
    chk("t4_pin_e6", bus.pin_out, 16'hFFFB);
    chk("t4_fall_e6", bus.edge_fall, 16'h0004);
    step(3);
    chk("t4_pin_e9", bus.pin_out, 16'hFFFB);
    step();
    chk("t4_pin_e10", bus.pin_out, 16'hFFFF);
    chk("t4_rise_e10", bus.edge_rise, 16'h0004);

    // 5: async reset mid-count
    bus.pad_in = 16'hFFFE;
    step(4);
    #1;
    rst_n      = 1'b0;
    bus.pad_in = 16'h0000;
    #1;
    chk("t5_pin_async", bus.pin_out, 16'h0000);
    chk("t5_strobe_async", bus.edge_rise | bus.edge_fall, 16'h0000);
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t5_strobe_rel", bus.edge_rise | bus.edge_fall, 16'h0000);
    end
    chk("t5_pin_rel", bus.pin_out, 16'h0000);

    // 6: debounce disabled mid-count on pin 3
    bus.pad_in = 16'h0008;
    step(4);
    chk("t6_pin_cnt2", bus.pin_out, 16'h0000);
    bus.db_en = 16'hFFF7;
    step();
    chk("t6_pin_follow", bus.pin_out, 16'h0008);
    chk("t6_rise", bus.edge_rise, 16'h0008);
    step();
    chk("t6_rise_off", bus.edge_rise, 16'h0000);
    bus.db_en = 16'hFFFF;

    // Random traffic: alternating slow/fast toggle phases, db_en changes, resets
    for (int c = 0; c < 3000; c++) begin
      fast = (c / 250) % 2;
      flip = '0;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(fast != 0 ? 1 : 11, 0) == 0) flip[i] = 1'b1;
      end
      bus.pad_in = bus.pad_in ^ flip;
      if ($urandom_range(29, 0) == 0) bus.db_en = 16'($urandom);
      if ($urandom_range(199, 0) == 0) begin
        #1;
        rst_n = 1'b0;
        step($urandom_range(2, 1));
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
